// File: rtl/clk_divider.sv
// clk_divider: programmable integer clock divider with bypass.
// The output period is N reference cycles. Even N gives a 50% duty cycle.
// Odd N gives floor(N/2) high cycles and ceil(N/2) low cycles.
// N = 0 or 1, or i_clk_en = 0, routes i_clk_ref straight to the output.
module clk_divider #(
  parameter int DIV_RATIO_WD = 8
) (
  input  logic                    i_clk_ref,
  input  logic                    i_rst,
  input  logic                    i_clk_en,
  input  logic [DIV_RATIO_WD-1:0] i_div_ratio,
  output logic                    o_clk_out
);

  localparam logic [DIV_RATIO_WD-1:0] C_ZERO = {DIV_RATIO_WD{1'b0}};
  localparam logic [DIV_RATIO_WD-1:0] C_ONE  = {{(DIV_RATIO_WD-1){1'b0}}, 1'b1};
  localparam logic [DIV_RATIO_WD-1:0] C_TWO  = {{(DIV_RATIO_WD-2){1'b0}}, 2'b10};

  // Phase state: cycle counter within the current phase and the divided clock.
  logic [DIV_RATIO_WD-1:0] r_cnt;
  logic                    r_div_q;

  // Next-state values and derived phase lengths.
  logic [DIV_RATIO_WD-1:0] w_cnt_nxt;
  logic                    w_div_nxt;
  logic [DIV_RATIO_WD-1:0] w_hi_len;
  logic [DIV_RATIO_WD-1:0] w_lo_len;
  logic [DIV_RATIO_WD-1:0] w_len;
  logic [DIV_RATIO_WD-1:0] w_len_m1;
  logic                    w_bypass;
  logic                    w_phase_end;

  // High phase is the shorter half; the low phase absorbs the odd cycle.
  assign w_hi_len = i_div_ratio >> 1;
  assign w_lo_len = i_div_ratio - w_hi_len;

  // Ratios below 2 cannot be divided, so they fall back to bypass.
  assign w_bypass = ~i_clk_en | (i_div_ratio < C_TWO);

  // Select the length of the phase currently being timed.
  always_comb begin
    w_len = w_lo_len;
    if (r_div_q) begin
      w_len = w_hi_len;
    end else begin
      w_len = w_lo_len;
    end
  end

  // LEN is at least 1 whenever divide mode is active, so LEN-1 never underflows
  // in a case that matters; in bypass the result is ignored.
  assign w_len_m1 = w_len - C_ONE;

  // ">=" rather than "==" so a ratio that shrinks mid-phase ends the phase at
  // once instead of letting the counter run on and wrap.
  assign w_phase_end = (r_cnt >= w_len_m1);

  // Next-state logic: hold cleared in bypass, otherwise count or toggle.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_div_nxt = r_div_q;
    if (w_bypass) begin
      w_cnt_nxt = C_ZERO;
      w_div_nxt = 1'b0;
    end else if (w_phase_end) begin
      w_cnt_nxt = C_ZERO;
      w_div_nxt = ~r_div_q;
    end else begin
      w_cnt_nxt = r_cnt + C_ONE;
      w_div_nxt = r_div_q;
    end
  end

  // State register with synchronous active-high reset; restart in low phase.
  always_ff @(posedge i_clk_ref) begin
    if (i_rst) begin
      r_cnt   <= C_ZERO;
      r_div_q <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_div_q <= w_div_nxt;
    end
  end

  // Output mux: reset forces low, bypass passes the reference clock through,
  // otherwise drive the divided clock register. A glitch at a mode switch is
  // accepted; consumers must not switch modes while relying on clean edges.
  always_comb begin
    o_clk_out = 1'b0;
    if (i_rst) begin
      o_clk_out = 1'b0;
    end else if (w_bypass) begin
      o_clk_out = i_clk_ref;
    end else begin
      o_clk_out = r_div_q;
    end
  end

endmodule

// File: tb/tb_clk_divider.sv
// tb_clk_divider: directed bench for clk_divider. Phase lengths are measured
// by sampling clk_out one time unit after each falling edge of clk_ref, where
// the divided output is stable; bypass is checked on both clock levels.
`timescale 1ns/1ps
module tb_clk_divider;

  logic       clk_ref = 1'b0;
  logic       rst;
  logic       clk_en;
  logic [7:0] div_ratio;
  logic       clk_out;

  int n_vec  = 0;
  int n_miss = 0;

  logic       mon_en  = 1'b0;
  logic [7:0] max_cnt = 8'd0;

  clk_divider #(.DIV_RATIO_WD(8)) dut (
    .i_clk_ref   (clk_ref),
    .i_rst       (rst),
    .i_clk_en    (clk_en),
    .i_div_ratio (div_ratio),
    .o_clk_out   (clk_out)
  );

  always #5 clk_ref = ~clk_ref;

  // Track the largest phase count reached while monitoring is enabled.
  always @(negedge clk_ref) begin
    if (mon_en && (dut.r_cnt > max_cnt)) max_cnt = dut.r_cnt;
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step_neg();
    @(negedge clk_ref);
    #1;
  endtask

  // Find a rising edge of clk_out, then measure one high and one low phase.
  task automatic measure(input string tag, input int exp_hi_ns, input int exp_lo_ns);
    int   guard = 0;
    int   hi = 0;
    int   lo = 0;
    logic prev;
    logic found = 1'b0;
    step_neg();
    prev = clk_out;
    while (!found && guard < 1000) begin
      step_neg();
      guard++;
      if (!prev && clk_out) found = 1'b1;
      prev = clk_out;
    end
    if (!found) begin
      check_eq({tag, "_rise_timeout"}, 0, 1);
    end else begin
      while (clk_out && guard < 2000) begin hi++; step_neg(); guard++; end
      while (!clk_out && guard < 3000) begin lo++; step_neg(); guard++; end
      check_eq({tag, "_high_ns"}, hi * 10, exp_hi_ns);
      check_eq({tag, "_low_ns"}, lo * 10, exp_lo_ns);
      check_eq({tag, "_period_ns"}, (hi + lo) * 10, exp_hi_ns + exp_lo_ns);
    end
  endtask

  // Count low samples from now until the first high sample.
  task automatic first_low(input string tag, input int exp_lo_ns);
    int lo = 0;
    #1;
    while (!clk_out && lo < 600) begin lo++; step_neg(); end
    check_eq({tag, "_first_low_ns"}, lo * 10, exp_lo_ns);
  endtask

  // Bypass: clk_out must follow clk_ref on both half-cycles.
  task automatic check_bypass(input string tag);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_ref); #2;
      check_eq({tag, "_hi"}, int'(clk_out), 1);
      @(negedge clk_ref); #2;
      check_eq({tag, "_lo"}, int'(clk_out), 0);
    end
  endtask

  initial begin
    int guard;
    rst       = 1'b1;
    clk_en    = 1'b0;
    div_ratio = 8'd2;

    // Reset forces the output low even in bypass.
    @(posedge clk_ref); #2;
    check_eq("rst_bypass_high_level", int'(clk_out), 0);
    @(negedge clk_ref);
    clk_en = 1'b1;
    @(posedge clk_ref); #2;
    check_eq("rst_divide", int'(clk_out), 0);
    @(negedge clk_ref);
    rst = 1'b0;

    // Divide ratios, including the 2 -> 3 switch.
    measure("n2", 10, 10);
    div_ratio = 8'd3;
    measure("n3", 10, 20);
    div_ratio = 8'd6;
    measure("n6", 30, 30);
    div_ratio = 8'd7;
    measure("n7", 30, 40);

    // Bypass by enable and by degenerate ratios.
    clk_en = 1'b0;
    check_bypass("byp_en0");
    clk_en = 1'b1;
    div_ratio = 8'd0;
    check_bypass("byp_n0");
    div_ratio = 8'd1;
    check_bypass("byp_n1");

    // Re-enable restarts with a full low phase.
    div_ratio = 8'd4;
    first_low("reen_n4", 20);
    measure("n4", 20, 20);

    // Mid-run reset during a high phase with N=7.
    div_ratio = 8'd7;
    guard = 0;
    while (!clk_out && guard < 50) begin step_neg(); guard++; end
    check_eq("n7_high_seen", int'(clk_out), 1);
    rst = 1'b1;
    @(posedge clk_ref); #2;
    check_eq("midrst_edge", int'(clk_out), 0);
    for (int i = 0; i < 3; i++) begin
      step_neg();
      check_eq("midrst_hold", int'(clk_out), 0);
    end
    rst = 1'b0;
    first_low("midrst_release", 40);

    // Maximum ratio; the counter must top out at LO_LEN-1.
    div_ratio = 8'd255;
    mon_en = 1'b1;
    measure("n255", 1270, 1280);
    mon_en = 1'b0;
    check_eq("n255_max_cnt", int'(max_cnt), 127);

    // Shrinking the ratio mid-phase ends the current (high) phase at once.
    for (int i = 0; i < 10; i++) step_neg();
    check_eq("shrink_pre_high", int'(clk_out), 1);
    div_ratio = 8'd4;
    step_neg();
    check_eq("shrink_end", int'(clk_out), 0);
    measure("n4_after_shrink", 20, 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
